// File: rtl/control_uni.sv
// control_uni -- RV32I main decoder.
//
// Maps a 32-bit instruction word to the datapath control word. Decode is
// combinational on iInstr; every output is a register, so the control word
// for an instruction is valid exactly one cycle after it is presented.
// Unsupported encodings produce the NOP control word with oIllegal=1.
//
// Optional feature: define RV32M_EN to decode the M extension
// (OP, funct7=0000001 -> MUL..REMU). Without it that encoding is illegal.
//
// Ports:
//   iCLK        in   1  clock, rising edge
//   iRST        in   1  synchronous active-low reset (loads the NOP word)
//   iInstr      in  32  instruction word
//   oOrigAULA   out  1  ALU A select: 0=rs1, 1=PC
//   oOrigBULA   out  1  ALU B select: 0=rs2, 1=immediate
//   oMem2Reg    out  2  writeback select: 00=ALU, 01=PC+4, 10=load data
//   oRegWrite   out  1  register-file write enable
//   oMemWrite   out  1  data memory write
//   oMemRead    out  1  data memory read
//   oALUControl out  5  ALU op code
//   oOrigPC     out  2  next-PC select: 00=PC+4, 01=branch, 10=jal, 11=jalr
//   oIllegal    out  1  unsupported or illegal encoding
module control_uni (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInstr,
  output logic        oOrigAULA,
  output logic        oOrigBULA,
  output logic [1:0]  oMem2Reg,
  output logic        oRegWrite,
  output logic        oMemWrite,
  output logic        oMemRead,
  output logic [4:0]  oALUControl,
  output logic [1:0]  oOrigPC,
  output logic        oIllegal
);

  localparam logic [4:0] ALU_AND    = 5'd0;
  localparam logic [4:0] ALU_OR     = 5'd1;
  localparam logic [4:0] ALU_XOR    = 5'd2;
  localparam logic [4:0] ALU_ADD    = 5'd3;
  localparam logic [4:0] ALU_SUB    = 5'd4;
  localparam logic [4:0] ALU_SLT    = 5'd5;
  localparam logic [4:0] ALU_SLTU   = 5'd6;
  localparam logic [4:0] ALU_SLL    = 5'd7;
  localparam logic [4:0] ALU_SRL    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd9;
  localparam logic [4:0] ALU_LUI    = 5'd10;
`ifdef RV32M_EN
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;
`endif
  localparam logic [4:0] ALU_NULL   = 5'd31;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef RV32M_EN
  localparam logic [6:0] F7_MEXT = 7'b0000001;
`endif

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  assign w_opcode = iInstr[6:0];
  assign w_funct3 = iInstr[14:12];
  assign w_funct7 = iInstr[31:25];

  // Register and immediate fields are consumed by the datapath, not here.
  logic w_unused;
  assign w_unused = ^{iInstr[24:15], iInstr[11:7]};

  logic       w_origA;
  logic       w_origB;
  logic [1:0] w_mem2reg;
  logic       w_regwrite;
  logic       w_memwrite;
  logic       w_memread;
  logic [4:0] w_alu;
  logic [1:0] w_origpc;
  logic       w_illegal;

  always_comb begin
    w_origA    = 1'b0;
    w_origB    = 1'b0;
    w_mem2reg  = 2'b00;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_memread  = 1'b0;
    w_alu      = ALU_NULL;
    w_origpc   = 2'b00;
    w_illegal  = 1'b0;

    if (iInstr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OPC_LOAD: begin
          w_origB    = 1'b1;
          w_alu      = ALU_ADD;
          w_mem2reg  = 2'b10;
          w_regwrite = 1'b1;
          w_memread  = 1'b1;
          if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
            w_illegal = 1'b1;
        end
        OPC_STORE: begin
          w_origB    = 1'b1;
          w_alu      = ALU_ADD;
          w_memwrite = 1'b1;
          if (w_funct3 > 3'b010)
            w_illegal = 1'b1;
        end
        OPC_OPIMM: begin
          w_origB    = 1'b1;
          w_regwrite = 1'b1;
          case (w_funct3)
            3'b000: w_alu = ALU_ADD;
            3'b010: w_alu = ALU_SLT;
            3'b011: w_alu = ALU_SLTU;
            3'b100: w_alu = ALU_XOR;
            3'b110: w_alu = ALU_OR;
            3'b111: w_alu = ALU_AND;
            3'b001: begin
              w_alu = ALU_SLL;
              if (w_funct7 != F7_BASE) w_illegal = 1'b1;
            end
            default: begin
              if (w_funct7 == F7_BASE)     w_alu = ALU_SRL;
              else if (w_funct7 == F7_ALT) w_alu = ALU_SRA;
              else                         w_illegal = 1'b1;
            end
          endcase
        end
        OPC_OP: begin
          w_regwrite = 1'b1;
          if (w_funct7 == F7_BASE) begin
            case (w_funct3)
              3'b000:  w_alu = ALU_ADD;
              3'b001:  w_alu = ALU_SLL;
              3'b010:  w_alu = ALU_SLT;
              3'b011:  w_alu = ALU_SLTU;
              3'b100:  w_alu = ALU_XOR;
              3'b101:  w_alu = ALU_SRL;
              3'b110:  w_alu = ALU_OR;
              default: w_alu = ALU_AND;
            endcase
          end else if (w_funct7 == F7_ALT) begin
            case (w_funct3)
              3'b000:  w_alu = ALU_SUB;
              3'b101:  w_alu = ALU_SRA;
              default: w_illegal = 1'b1;
            endcase
`ifdef RV32M_EN
          end else if (w_funct7 == F7_MEXT) begin
            case (w_funct3)
              3'b000:  w_alu = ALU_MUL;
              3'b001:  w_alu = ALU_MULH;
              3'b010:  w_alu = ALU_MULHSU;
              3'b011:  w_alu = ALU_MULHU;
              3'b100:  w_alu = ALU_DIV;
              3'b101:  w_alu = ALU_DIVU;
              3'b110:  w_alu = ALU_REM;
              default: w_alu = ALU_REMU;
            endcase
`endif
          end else begin
            w_illegal = 1'b1;
          end
        end
        OPC_LUI: begin
          w_origB    = 1'b1;
          w_alu      = ALU_LUI;
          w_regwrite = 1'b1;
        end
        OPC_AUIPC: begin
          w_origA    = 1'b1;
          w_origB    = 1'b1;
          w_alu      = ALU_ADD;
          w_regwrite = 1'b1;
        end
        OPC_BRANCH: begin
          w_origpc = 2'b01;
          w_alu    = ALU_SUB;
          if (w_funct3 == 3'b010 || w_funct3 == 3'b011)
            w_illegal = 1'b1;
        end
        OPC_JAL: begin
          w_mem2reg  = 2'b01;
          w_regwrite = 1'b1;
          w_origpc   = 2'b10;
          w_alu      = ALU_ADD;
        end
        OPC_JALR: begin
          w_origB    = 1'b1;
          w_alu      = ALU_ADD;
          w_mem2reg  = 2'b01;
          w_regwrite = 1'b1;
          w_origpc   = 2'b11;
          if (w_funct3 != 3'b000)
            w_illegal = 1'b1;
        end
        default: w_illegal = 1'b1;
      endcase
    end

    // Any illegal case collapses to the NOP word so no write can leak out
    // from a partially decoded opcode.
    if (w_illegal) begin
      w_origA    = 1'b0;
      w_origB    = 1'b0;
      w_mem2reg  = 2'b00;
      w_regwrite = 1'b0;
      w_memwrite = 1'b0;
      w_memread  = 1'b0;
      w_alu      = ALU_NULL;
      w_origpc   = 2'b00;
    end
  end

  logic       r_origA;
  logic       r_origB;
  logic [1:0] r_mem2reg;
  logic       r_regwrite;
  logic       r_memwrite;
  logic       r_memread;
  logic [4:0] r_alu;
  logic [1:0] r_origpc;
  logic       r_illegal;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_origA    <= 1'b0;
      r_origB    <= 1'b0;
      r_mem2reg  <= 2'b00;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_alu      <= ALU_NULL;
      r_origpc   <= 2'b00;
      r_illegal  <= 1'b0;
    end else begin
      r_origA    <= w_origA;
      r_origB    <= w_origB;
      r_mem2reg  <= w_mem2reg;
      r_regwrite <= w_regwrite;
      r_memwrite <= w_memwrite;
      r_memread  <= w_memread;
      r_alu      <= w_alu;
      r_origpc   <= w_origpc;
      r_illegal  <= w_illegal;
    end
  end

  assign oOrigAULA   = r_origA;
  assign oOrigBULA   = r_origB;
  assign oMem2Reg    = r_mem2reg;
  assign oRegWrite   = r_regwrite;
  assign oMemWrite   = r_memwrite;
  assign oMemRead    = r_memread;
  assign oALUControl = r_alu;
  assign oOrigPC     = r_origpc;
  assign oIllegal    = r_illegal;

endmodule

// File: tb/tb_control_uni.sv
module tb_control_uni;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [31:0] iInstr = 32'h0000_0033;
  logic        oOrigAULA, oOrigBULA, oRegWrite, oMemWrite, oMemRead, oIllegal;
  logic [1:0]  oMem2Reg, oOrigPC;
  logic [4:0]  oALUControl;

  control_uni dut (
    .iCLK(iCLK), .iRST(iRST), .iInstr(iInstr),
    .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA), .oMem2Reg(oMem2Reg),
    .oRegWrite(oRegWrite), .oMemWrite(oMemWrite), .oMemRead(oMemRead),
    .oALUControl(oALUControl), .oOrigPC(oOrigPC), .oIllegal(oIllegal)
  );

  always #5 iCLK = ~iCLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          drive_done = 1'b0;

  typedef struct {
    logic [14:0] exp;
    logic [31:0] instr;
    string       name;
  } sb_t;
  sb_t sbq[$];

  // Packed word: {ill, A, B, m2r[1:0], rw, mw, mr, alu[4:0], pc[1:0]}
  function automatic logic [14:0] pack(input bit ill, input bit a, input bit b,
      input int m2r, input bit rw, input bit mw, input bit mr,
      input int alu, input int pc);
    logic [1:0] m2r_v = m2r[1:0];
    logic [4:0] alu_v = alu[4:0];
    logic [1:0] pc_v  = pc[1:0];
    return {ill, a, b, m2r_v, rw, mw, mr, alu_v, pc_v};
  endfunction

  function automatic logic [14:0] nop_word(input bit ill);
    return pack(ill, 0, 0, 0, 0, 0, 0, 31, 0);
  endfunction

  // funct3 -> op code for register-register / register-immediate arithmetic
  // (funct3 101 is the logical right shift; the arithmetic variant is +1).
  int f3_alu [8] = '{3, 7, 5, 6, 2, 8, 1, 0};
`ifdef RV32M_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  // Reference model built from the instruction-class rules.
  function automatic logic [14:0] model(input logic [31:0] ins);
    int op = int'(ins[6:0]);
    int f3 = int'(ins[14:12]);
    int f7 = int'(ins[31:25]);
    if (ins[1:0] != 2'b11) return nop_word(1);
    case (op)
      'h03: return (f3 == 3 || f3 >= 6) ? nop_word(1) : pack(0,0,1,2,1,0,1,3,0);
      'h23: return (f3 > 2) ? nop_word(1) : pack(0,0,1,0,1 & 0,1,0,3,0);
      'h13: begin
        if (f3 == 1 && f7 != 0) return nop_word(1);
        if (f3 == 5) begin
          if (f7 == 0)    return pack(0,0,1,0,1,0,0,8,0);
          if (f7 == 'h20) return pack(0,0,1,0,1,0,0,9,0);
          return nop_word(1);
        end
        return pack(0,0,1,0,1,0,0,f3_alu[f3],0);
      end
      'h33: begin
        if (f7 == 0)    return pack(0,0,0,0,1,0,0,f3_alu[f3],0);
        if (f7 == 'h20) begin
          if (f3 == 0) return pack(0,0,0,0,1,0,0,4,0);
          if (f3 == 5) return pack(0,0,0,0,1,0,0,9,0);
          return nop_word(1);
        end
        if (f7 == 1 && MEXT) return pack(0,0,0,0,1,0,0,11 + f3,0);
        return nop_word(1);
      end
      'h37: return pack(0,0,1,0,1,0,0,10,0);
      'h17: return pack(0,1,1,0,1,0,0,3,0);
      'h63: return (f3 == 2 || f3 == 3) ? nop_word(1) : pack(0,0,0,0,0,0,0,4,1);
      'h6F: return pack(0,0,0,1,1,0,0,3,2);
      'h67: return (f3 != 0) ? nop_word(1) : pack(0,0,1,1,1,0,0,3,3);
      default: return nop_word(1);
    endcase
  endfunction

  task automatic drive(input bit rst_n, input logic [31:0] ins,
                       input logic [14:0] exp, input string name);
    sb_t e;
    @(negedge iCLK);
    iRST   = rst_n;
    iInstr = ins;
    e.exp = exp; e.instr = ins; e.name = name;
    sbq.push_back(e);
  endtask

  // Monitor: outputs are registered, so each edge presents the word for the
  // entry pushed in the preceding half-cycle.
  initial begin
    sb_t e;
    logic [14:0] act;
    forever begin
      @(posedge iCLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = {oIllegal, oOrigAULA, oOrigBULA, oMem2Reg, oRegWrite, oMemWrite,
               oMemRead, oALUControl, oOrigPC};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s instr=%08h actual={ill,A,B,m2r,rw,mw,mr,alu,pc}=%b,%b,%b,%b,%b,%b,%b,%0d,%b required=%b,%b,%b,%b,%b,%b,%b,%0d,%b",
                   e.name, e.instr, act[14], act[13], act[12], act[11:10], act[9],
                   act[8], act[7], act[6:2], act[1:0], e.exp[14], e.exp[13],
                   e.exp[12], e.exp[11:10], e.exp[9], e.exp[8], e.exp[7],
                   e.exp[6:2], e.exp[1:0]);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [14:0] exp;
    string       name;
  } dir_t;

  initial begin
    dir_t dl[$];
    logic [31:0] ins;
    int unsigned kind, budget;
    int opcs [9] = '{'h03, 'h23, 'h13, 'h33, 'h37, 'h17, 'h63, 'h6F, 'h67};
    int f7s  [4] = '{0, 'h20, 1, 0};

    // Reset held for two edges with a legal instruction on the bus.
    drive(1'b0, 32'h0000_0033, nop_word(0), "reset0");
    drive(1'b0, 32'h0000_0033, nop_word(0), "reset1");
    drive(1'b1, 32'h0000_0033, pack(0,0,0,0,1,0,0,3,0), "add_after_reset");

    dl.push_back('{32'h40B5_0533, pack(0,0,0,0,1,0,0,4,0),  "sub"});
    dl.push_back('{32'h4035_5513, pack(0,0,1,0,1,0,0,9,0),  "srai"});
    dl.push_back('{32'h0005_A503, pack(0,0,1,2,1,0,1,3,0),  "lw"});
    dl.push_back('{32'h00A5_A023, pack(0,0,1,0,0,1,0,3,0),  "sw"});
    dl.push_back('{32'h00B5_0463, pack(0,0,0,0,0,0,0,4,1),  "beq"});
    dl.push_back('{32'h0080_00EF, pack(0,0,0,1,1,0,0,3,2),  "jal"});
    dl.push_back('{32'h0000_8067, pack(0,0,1,1,1,0,0,3,3),  "jalr"});
    dl.push_back('{32'h1234_5537, pack(0,0,1,0,1,0,0,10,0), "lui"});
    dl.push_back('{32'h0000_0517, pack(0,1,1,0,1,0,0,3,0),  "auipc"});
    dl.push_back('{32'hFFFF_FFFF, nop_word(1),              "all_ones"});
    dl.push_back('{32'h0000_5067, nop_word(1),              "jalr_f3_101"});
`ifdef RV32M_EN
    dl.push_back('{32'h02B5_0533, pack(0,0,0,0,1,0,0,11,0), "mul"});
`else
    dl.push_back('{32'h02B5_0533, nop_word(1),              "mul"});
`endif
    dl.push_back('{32'h0000_3003, nop_word(1),              "load_f3_011"});
    dl.push_back('{32'h0000_6003, nop_word(1),              "load_f3_110"});
    dl.push_back('{32'h0000_4003, pack(0,0,1,2,1,0,1,3,0),  "lbu"});
    dl.push_back('{32'h0000_3023, nop_word(1),              "store_f3_011"});
    dl.push_back('{32'h0000_2063, nop_word(1),              "branch_f3_010"});
    dl.push_back('{32'h0000_7063, pack(0,0,0,0,0,0,0,4,1),  "bgeu"});
    dl.push_back('{32'h0000_1013, pack(0,0,1,0,1,0,0,7,0),  "slli"});
    dl.push_back('{32'h0200_1013, nop_word(1),              "slli_bad_f7"});
    dl.push_back('{32'h8000_5013, nop_word(1),              "srli_bad_f7"});
    dl.push_back('{32'h4000_1033, nop_word(1),              "op_alt_f3_001"});
    dl.push_back('{32'h0400_0033, nop_word(1),              "op_bad_f7"});
    dl.push_back('{32'h0000_0032, nop_word(1),              "low_bits_10"});
    dl.push_back('{32'h0000_000B, nop_word(1),              "custom0"});

    foreach (dl[i]) drive(1'b1, dl[i].instr, dl[i].exp, dl[i].name);

    // Mid-stream reset overrides a legal instruction, then decoding resumes.
    drive(1'b0, 32'h0005_A503, nop_word(0), "reset_mid");
    drive(1'b1, 32'h0005_A503, pack(0,0,1,2,1,0,1,3,0), "lw_after_reset");

    for (int n = 0; n < 800; n++) begin
      kind = $urandom_range(0, 99);
      ins  = $urandom;
      if (kind >= 25) begin
        ins[6:0]   = opcs[$urandom_range(0, 8)][6:0];
        ins[31:25] = (kind >= 90) ? ins[31:25] : f7s[$urandom_range(0, 3)][6:0];
      end
      if ($urandom_range(0, 99) < 4)
        drive(1'b0, ins, nop_word(0), "rand_reset");
      else
        drive(1'b1, ins, model(ins), "rand");
    end

    budget = 0;
    while (sbq.size() > 0 && budget < 20) begin
      @(posedge iCLK);
      budget++;
    end
    #2;
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
